rom_burst_reader: RTL and testbench
===================================

Name: rom_burst_reader

Overview:
- Sequential read master for the team's 16x8 combinational ROM (4-bit address in, 8-bit data out).
- Accepts a burst command (start address, length) and drives the ROM address.
- Streams the returned bytes to a downstream consumer over a valid/ready interface, one byte per cycle at full throughput.
- Sits between the ROM and any byte consumer: UART TX, pattern generator or checker.

Parameters:
- ADDR_W, 4, ROM address width; burst address wraps modulo 2^ADDR_W.
- DATA_W, 8, ROM data width.
- LEN_W, 5, burst length field width; legal lengths are 1..2^LEN_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  burst request; sampled only in IDLE.
- start_addr  input  ADDR_W  first ROM address of the burst.
- len  input  LEN_W  number of bytes to read; 0 is ignored.
- busy  output  1  high from the cycle after an accepted start until the burst completes.
- rom_add  output  ADDR_W  registered address to the ROM.
- rom_data  input  DATA_W  ROM data, combinational from rom_add.
- dout_data  output  DATA_W  streamed byte.
- dout_valid  output  1  dout_data holds a valid byte.
- dout_ready  input  1  consumer accepts the byte.
- dout_last  output  1  qualifies the final byte of the burst.
- done  output  1  one-cycle pulse after the final byte handshake.

Behaviour:
- Reset (async assert, sync release) forces:
  - state to IDLE;
  - rom_add, cnt, dout_data to 0;
  - busy, dout_valid, dout_last, done to 0.
- Reset asserted mid-burst aborts the burst: no done pulse and no further bytes are emitted.
- States are IDLE and RUN.
- IDLE → RUN on a rising edge where start=1 and len!=0:
  - addr_reg ← start_addr, cnt ← len.
  - busy goes high the next cycle.
  - start with len=0 is ignored; the state stays IDLE.
- In RUN, start is ignored entirely; the in-progress burst is unaffected.
- rom_add = addr_reg at all times. The ROM is combinational, so rom_data is valid in the same cycle.
- Load condition: ld = RUN & (cnt!=0) & (!dout_valid | dout_ready).
- On ld:
  - dout_data ← rom_data, dout_valid ← 1, dout_last ← (cnt==1).
  - addr_reg ← addr_reg+1, wrapping 0xF → 0x0.
  - cnt ← cnt-1.
- No ld, and dout_valid & dout_ready: dout_valid ← 0, dout_last ← 0.
- No ld, and dout_ready=0: dout_data, dout_valid and dout_last hold stable. Data never changes while valid and not accepted.
- Final handshake (dout_valid & dout_ready & dout_last):
  - next cycle: done=1 for exactly one cycle, busy=0, dout_valid=0, state=IDLE.
  - A new start may be sampled in that same done cycle.
- Latency: start sampled at edge T → first dout_valid=1 after edge T+2.
- Throughput: with dout_ready held high, one byte per cycle. Burst of N ends with done asserted after edge T+N+2.
- Lengths above 16 repeat ROM contents through the wrap. Example: start_addr=0xF, len=18 gives addresses F,0,1,…,F,0.
- Byte ordering matches ascending (wrapping) address order exactly; no duplicates or drops under any dout_ready pattern.

Test Plan:
ROM contents used by the bench: 0x0=5d, 0x1=7a, 0x2=cd, 0x3=6e, 0xE=2b, 0xF=5d.
- Reset then idle: all outputs 0 and rom_add=0. start=1 with len=0 → busy stays 0, no dout_valid.
- start_addr=0x0, len=4, dout_ready=1 → bytes 5d,7a,cd,6e on 4 consecutive cycles starting 2 cycles after start; dout_last only on 6e; done pulses 1 cycle later.
- start_addr=0xE, len=3, dout_ready=1 → 2b,5d,5d (addresses E,F,0); rom_add wraps to 0x0.
- start_addr=0x1, len=3, dout_ready toggling 0,0,1,0,1,1 → each byte (7a,cd,6e) held stable while ready=0; exactly 3 handshakes, no loss or duplication.
- Mid-burst: start pulsed during a busy burst → ignored. Then rst asserted asynchronously mid-burst → outputs cleared immediately, no done. After release, a new start_addr=0x2, len=1 yields a single cd with dout_last=1.

Source files
------------

// File: rtl/rom_burst_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_burst_reader_if
// Brief    : Command, ROM-address and byte-stream bundle for rom_burst_reader.
// Revision : 1.0 - initial release
// ============================================================================
interface rom_burst_reader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 5
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic [ADDR_W-1:0] rom_add;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] dout_data;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;
    logic              done;

    // master is the burst reader; slave is the command source, ROM and consumer
    modport master (
        input  start, start_addr, len, rom_data, dout_ready,
        output busy, rom_add, dout_data, dout_valid, dout_last, done
    );

    modport slave (
        output start, start_addr, len, rom_data, dout_ready,
        input  busy, rom_add, dout_data, dout_valid, dout_last, done
    );
endinterface
`default_nettype wire

// File: rtl/rom_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : rom_burst_reader
// Brief    : Reads a wrapping burst from a combinational ROM and streams the
//            bytes over valid/ready, one byte per cycle at full throughput.
// Revision : 1.0 - initial release
// ============================================================================
module rom_burst_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 5
) (
    input  wire logic          clk,
    input  wire logic          rst,
    rom_burst_reader_if.master bus
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic              r_arm;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_dout_data;
    logic              r_dout_valid;
    logic              r_dout_last;
    logic              r_busy;
    logic              r_done;

    logic w_accept;
    logic w_ld;
    logic w_fin;

    assign w_accept = (r_state == c_IDLE) && bus.start && (bus.len != '0);
    // r_arm delays the first capture by one cycle so the freshly registered
    // start address has a full cycle on the ROM before its byte is taken
    assign w_ld     = (r_state == c_RUN) && r_arm && (r_cnt != '0) &&
                      (!r_dout_valid || bus.dout_ready);
    assign w_fin    = r_dout_valid && bus.dout_ready && r_dout_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_arm        <= 1'b0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_dout_data  <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_state <= c_RUN;
                        r_addr  <= bus.start_addr;
                        r_cnt   <= bus.len;
                        r_busy  <= 1'b1;
                        r_arm   <= 1'b0;
                    end
                end
                c_RUN: begin
                    r_arm <= 1'b1;
                    if (w_ld) begin
                        r_dout_data  <= bus.rom_data;
                        r_dout_valid <= 1'b1;
                        r_dout_last  <= (r_cnt == LEN_W'(1));
                        r_addr       <= r_addr + ADDR_W'(1);
                        r_cnt        <= r_cnt - LEN_W'(1);
                    end else if (r_dout_valid && bus.dout_ready) begin
                        r_dout_valid <= 1'b0;
                        r_dout_last  <= 1'b0;
                    end
                    // the last byte leaves with cnt already zero, so no load competes here
                    if (w_fin) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_arm   <= 1'b0;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.rom_add    = r_addr;
    assign bus.dout_data  = r_dout_data;
    assign bus.dout_valid = r_dout_valid;
    assign bus.dout_last  = r_dout_last;
    assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rom_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_burst_reader
// Brief    : Directed table plus random bursts against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_burst_reader;

    typedef struct {
        logic [3:0]  addr;
        logic [4:0]  len;
        logic [15:0] rdy;
        logic [7:0]  exp_first;
        logic [7:0]  exp_final;
    } vec_t;

    logic clk;
    logic rst;
    logic [7:0] rom [0:15];

    rom_burst_reader_if #(.ADDR_W(4), .DATA_W(8), .LEN_W(5)) bus ();

    rom_burst_reader #(.ADDR_W(4), .DATA_W(8), .LEN_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rom_data = rom[bus.rom_add];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of the bytes still owed for the current burst
    logic [7:0] q [$];
    logic       m_out = 1'b0;
    logic       exp_done = 1'b0;
    logic [3:0] m_base = 4'h0;
    logic [4:0] m_len = 5'd0;
    logic [3:0] m_addr_hold = 4'h0;
    int         m_hs = 0;
    int         k = 0;
    int         done_count = 0;
    int         done_k = 0;
    logic [7:0] mon_first = 8'h00;
    logic [7:0] mon_final = 8'h00;

    always @(negedge clk) begin
        logic       was_out;
        logic       exp_done_n;
        logic [3:0] ea;
        if (rst) begin
            chk("rst_busy",  32'(bus.busy), 0);
            chk("rst_valid", 32'(bus.dout_valid), 0);
            chk("rst_last",  32'(bus.dout_last), 0);
            chk("rst_done",  32'(bus.done), 0);
            chk("rst_data",  32'(bus.dout_data), 0);
            chk("rst_addr",  32'(bus.rom_add), 0);
            q.delete();
            m_out = 1'b0;
            exp_done = 1'b0;
            m_addr_hold = 4'h0;
        end else begin
            k++;
            was_out = m_out;
            exp_done_n = 1'b0;
            chk("busy", 32'(bus.busy), 32'(m_out));
            chk("done", 32'(bus.done), 32'(exp_done));
            if (bus.done) begin
                done_count++;
                done_k = k;
            end
            if (!m_out) begin
                chk("idle_valid", 32'(bus.dout_valid), 0);
                chk("idle_rom_add", 32'(bus.rom_add), 32'(m_addr_hold));
            end else begin
                if (k <= 2) chk("latency_valid", 32'(bus.dout_valid), 0);
                else        chk("stream_valid", 32'(bus.dout_valid), 32'(q.size() != 0));
                ea = m_base + 4'(m_hs) + {3'b000, bus.dout_valid};
                chk("rom_add", 32'(bus.rom_add), 32'(ea));
                if (bus.dout_valid && q.size() != 0) begin
                    chk("data", 32'(bus.dout_data), 32'(q[0]));
                    chk("last", 32'(bus.dout_last), 32'(q.size() == 1));
                end
                if (bus.dout_valid && bus.dout_ready) begin
                    if (m_hs == 0) mon_first = bus.dout_data;
                    if (bus.dout_last) mon_final = bus.dout_data;
                    m_hs++;
                    if (q.size() != 0) void'(q.pop_front());
                    if (q.size() == 0) begin
                        m_out = 1'b0;
                        exp_done_n = 1'b1;
                        m_addr_hold = m_base + 4'(m_len);
                    end
                end
            end
            if (!was_out && bus.start && bus.len != 5'd0) begin
                m_out  = 1'b1;
                m_base = bus.start_addr;
                m_len  = bus.len;
                m_hs   = 0;
                k      = 0;
                for (int i = 0; i < int'(bus.len); i++)
                    q.push_back(rom[4'(int'(bus.start_addr) + i)]);
            end
            exp_done = exp_done_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while (m_out && cyc < 300) begin
            tick();
            cyc++;
        end
        chk({name, "_idle_timeout"}, 32'(m_out), 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int         d0;
        int         cyc;
        logic [3:0] ri;
        wait_idle("vec");
        d0 = done_count;
        bus.start      = 1'b1;
        bus.start_addr = v.addr;
        bus.len        = v.len;
        bus.dout_ready = v.rdy[0];
        tick();
        bus.start = 1'b0;
        if (v.len == 5'd0) begin
            repeat (3) tick();
            chk("len0_busy", 32'(bus.busy), 0);
            chk("len0_valid", 32'(bus.dout_valid), 0);
            chk("len0_no_done", 32'(done_count), 32'(d0));
            return;
        end
        cyc = 1;
        while (done_count == d0 && cyc < 300) begin
            ri = cyc[3:0];
            bus.dout_ready = v.rdy[ri];
            tick();
            cyc++;
        end
        chk($sformatf("vec%0d_done_seen", idx), 32'(done_count != d0), 1);
        chk($sformatf("vec%0d_handshakes", idx), 32'(m_hs), 32'(v.len));
        chk($sformatf("vec%0d_first", idx), 32'(mon_first), 32'(v.exp_first));
        chk($sformatf("vec%0d_final", idx), 32'(mon_final), 32'(v.exp_final));
        if (v.rdy == 16'hFFFF)
            chk($sformatf("vec%0d_done_cycle", idx), 32'(done_k), 32'(int'(v.len) + 3));
        bus.dout_ready = 1'b1;
    endtask

    vec_t vecs [5];

    initial begin
        int d0;
        rom[0]  = 8'h5d; rom[1]  = 8'h7a; rom[2]  = 8'hcd; rom[3]  = 8'h6e;
        rom[4]  = 8'h11; rom[5]  = 8'h22; rom[6]  = 8'h33; rom[7]  = 8'h44;
        rom[8]  = 8'h55; rom[9]  = 8'h66; rom[10] = 8'h77; rom[11] = 8'h88;
        rom[12] = 8'h99; rom[13] = 8'haa; rom[14] = 8'h2b; rom[15] = 8'h5d;

        vecs[0] = '{addr: 4'h0, len: 5'd0,  rdy: 16'hFFFF, exp_first: 8'h00, exp_final: 8'h00};
        vecs[1] = '{addr: 4'h0, len: 5'd4,  rdy: 16'hFFFF, exp_first: 8'h5d, exp_final: 8'h6e};
        vecs[2] = '{addr: 4'hE, len: 5'd3,  rdy: 16'hFFFF, exp_first: 8'h2b, exp_final: 8'h5d};
        // ready 0,0,1,0,1,1 from the cycle the first byte appears
        vecs[3] = '{addr: 4'h1, len: 5'd3,  rdy: 16'hFFA0, exp_first: 8'h7a, exp_final: 8'h6e};
        vecs[4] = '{addr: 4'hF, len: 5'd18, rdy: 16'hFFFF, exp_first: 8'h5d, exp_final: 8'h5d};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.start_addr = 4'h0;
        bus.len = 5'd0;
        bus.dout_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("post_rst_busy", 32'(bus.busy), 0);
        chk("post_rst_rom_add", 32'(bus.rom_add), 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);
        chk("wrap_rom_add", 32'(bus.rom_add), 32'h1);

        // start during a busy burst, then asynchronous reset mid-burst
        wait_idle("mid");
        bus.start = 1'b1; bus.start_addr = 4'h0; bus.len = 5'd8; bus.dout_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.start = 1'b1; bus.start_addr = 4'h5; bus.len = 5'd2;
        tick();
        bus.start = 1'b0;
        chk("mid_still_busy", 32'(bus.busy), 1);
        d0 = done_count;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(bus.dout_valid), 0);
        chk("async_busy", 32'(bus.busy), 0);
        chk("async_data", 32'(bus.dout_data), 0);
        chk("async_rom_add", 32'(bus.rom_add), 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("abort_no_done", 32'(done_count), 32'(d0));
        run_vec('{addr: 4'h2, len: 5'd1, rdy: 16'hFFFF, exp_first: 8'hcd, exp_final: 8'hcd}, 5);

        // random commands, ready and start pulses; the monitor judges every cycle
        for (int c = 0; c < 1500; c++) begin
            bus.start      = ($urandom_range(0, 5) == 0);
            bus.start_addr = 4'($urandom_range(0, 15));
            bus.len        = 5'($urandom_range(0, 31));
            bus.dout_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.start = 1'b0;
        bus.dout_ready = 1'b1;
        wait_idle("drain");
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
